y_serial_sub: RTL
=================

Y_SERIAL_SUB -- requirements
Module: y_serial_sub

Interface
REQ-001 Parameter W, default 32, operand and result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a subtraction; sampled at a rising edge of clk.
REQ-005 a  input  W  minuend; captured when start is accepted.
REQ-006 b  input  W  subtrahend; captured when start is accepted.
REQ-007 ready  output  1  high when a start would be accepted (state IDLE or DONE).
REQ-008 busy  output  1  high while bits are being processed (state RUN).
REQ-009 done  output  1  one-cycle pulse marking that the result is valid.
REQ-010 z  output  W  difference a - b, modulo 2^W.
REQ-011 cout  output  1  final carry of a + ~b + 1; 1 = no borrow (a >= b unsigned).
REQ-012 ovf  output  1  signed (two's complement) overflow of a - b.
REQ-013 zero  output  1  high when z == 0.

Function
REQ-014 Subtraction shall be computed bit-serially, LSB first, one bit per clock, as a + ~b + carry, using one 1-bit full-add cell with b inverted.
REQ-015 The carry register shall be loaded with 1 when start is accepted and updated with the cell's carry-out on every RUN cycle.
REQ-016 The FSM shall have states IDLE, RUN and DONE.
REQ-017 IDLE -> RUN when start = 1; otherwise the FSM shall remain in IDLE.
REQ-018 RUN shall last exactly W cycles, with a bit counter running 0..W-1; RUN -> DONE after the cycle in which counter = W-1.
REQ-019 DONE shall last one cycle; DONE -> RUN if start = 1, else DONE -> IDLE.
REQ-020 Acceptance: when start is accepted on edge k, a and b shall be latched into shift registers, busy shall be high for cycles k+1..k+W, and done shall be high in cycle k+W+1.
REQ-021 start while busy = 1 shall be ignored, with no effect on the operation in progress or its result.
REQ-022 a and b shall not be re-sampled during RUN; changes on those inputs after acceptance shall have no effect.
REQ-023 Result bits shall be shifted into z from the MSB end, so that z holds the full difference at DONE.
REQ-024 z shall hold undefined-but-stable partial values during RUN; the bench shall not check z while busy.
REQ-025 z, cout, ovf and zero shall be valid from the done cycle onward and shall hold until the next accepted start.
REQ-026 cout shall be the carry register value after the W-th bit.
REQ-027 ovf shall equal (a[W-1] != b[W-1]) && (z[W-1] != a[W-1]), using the latched operands.
REQ-028 zero shall be derived from the final z and shall be registered or held with the other results.
REQ-029 A start accepted in DONE shall produce a new done pulse exactly W+1 cycles later, with no idle gap required between operations.
REQ-030 done and busy shall never be high in the same cycle; ready shall equal !busy.

Reset
REQ-031 While rst = 1, the block shall immediately (asynchronously) enter IDLE, with ready = 1, busy = 0, done = 0, z = 0, cout = 0, ovf = 0, zero = 0, counter = 0, carry = 0.
REQ-032 rst asserted during RUN shall abort the operation; no done pulse shall be produced for it.
REQ-033 A start present in the first clock edge after rst deasserts shall be accepted normally.

Verification
REQ-034 With W=8, a=0x05, b=0x03, start pulsed -> done exactly 9 cycles later with z=0x02, cout=1, ovf=0, zero=0.
REQ-035 With W=8, a=0x03, b=0x05 -> z=0xFE, cout=0, ovf=0, zero=0.
REQ-036 With W=8, a=0x80, b=0x01 -> z=0x7F, cout=1, ovf=1; a=0x7F, b=0xFF -> z=0x80, ovf=1, cout=0.
REQ-037 With W=8, a=0x00, b=0x00 -> z=0x00, cout=1, zero=1; then start held in the DONE cycle with a=0x10, b=0x01 -> back-to-back run, z=0x0F.
REQ-038 Start a=0x40, b=0x20; pulse start again with a=0xFF, b=0x00 at cycle 3 of RUN -> second start ignored, result z=0x20.
REQ-039 Assert rst at cycle 4 of RUN -> outputs at reset values, no done pulse; after release, a=0x09, b=0x09 -> z=0x00, zero=1, cout=1.

Source files
------------

// File: rtl/y_serial_sub.sv
// Bit-serial subtractor: computes a - b LSB first as a + ~b + 1 with one full-add cell,
// one bit per clock, and reports carry, signed overflow and zero flags with the result.
module y_serial_sub #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] z,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned CntW = $clog2(W);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    a_q, b_q, z_q;
  logic            carry_q, a_msb_q, b_msb_q, ovf_q, zero_q;
  logic            accept, last, sum, carry_out;
  logic [W-1:0]    z_shift;

  assign accept    = start && (state_q != StRun);
  assign last      = (state_q == StRun) && (cnt_q == CntW'(W - 1));
  assign sum       = a_q[0] ^ ~b_q[0] ^ carry_q;
  assign carry_out = (a_q[0] & ~b_q[0]) | (a_q[0] & carry_q) | (~b_q[0] & carry_q);
  // Result enters at the MSB so the first (LSB) bit lands at z[0] after W shifts.
  assign z_shift   = {sum, z_q[W-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready = (state_q != StRun);
    busy  = (state_q == StRun);
    done  = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      a_msb_q <= a[W-1];
      b_msb_q <= b[W-1];
      carry_q <= 1'b1;
      cnt_q   <= '0;
    end else if (state_q == StRun) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= carry_out;
      z_q     <= z_shift;
      if (last) begin
        cnt_q  <= '0;
        zero_q <= (z_shift == '0);
        ovf_q  <= (a_msb_q != b_msb_q) && (sum != a_msb_q);
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign z    = z_q;
  assign cout = carry_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
